// File: rtl/mypc_sequencer_if.sv
// Sequencer bus: program-load port, datapath flags in, instruction/status out.
//   master : host/datapath side (drives start, program load, zf_in, stop_in)
//   slave  : the sequencer (drives pc_instr/A/B, exec_strobe, pc, busy/halted/fault)
interface mypc_sequencer_if;
  logic        start;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [11:0] prog_data;
  logic        zf_in;
  logic        stop_in;
  logic [3:0]  pc_instr;
  logic [3:0]  A;
  logic [3:0]  B;
  logic        exec_strobe;
  logic [3:0]  pc;
  logic        busy;
  logic        halted;
  logic        fault;

  modport master (
    output start, prog_we, prog_addr, prog_data, zf_in, stop_in,
    input  pc_instr, A, B, exec_strobe, pc, busy, halted, fault
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data, zf_in, stop_in,
    output pc_instr, A, B, exec_strobe, pc, busy, halted, fault
  );
endinterface

// File: rtl/mypc_sequencer.sv
// Program sequencer for the 4-bit computer datapath.
// Holds a 16-entry program memory of {instr, A, B} words, fetches one entry
// per instruction and presents it with a single-cycle exec_strobe. Resolves
// JZ/HLT from the datapath's zf_in/stop_in and keeps a private return stack
// for CALL/RET. Each instruction takes exactly FETCH -> ISSUE -> WAIT.
// Ports:
//   mypc_clock : system clock, rising edge
//   mypc_reset : synchronous active-high reset
//   bus        : slave side of mypc_sequencer_if
//                in : start, prog_we, prog_addr, prog_data, zf_in, stop_in
//                out: pc_instr, A, B, exec_strobe, pc, busy, halted, fault
module mypc_sequencer #(
  parameter int unsigned RS_DEPTH   = 4,
  parameter int unsigned PROG_WORDS = 16
) (
  input  logic             mypc_clock,
  input  logic             mypc_reset,
  mypc_sequencer_if.slave  bus
);

  localparam int unsigned IDXW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int unsigned PTRW = $clog2(RS_DEPTH + 1);

  localparam logic [3:0] OP_JZ   = 4'd10;
  localparam logic [3:0] OP_CALL = 4'd13;
  localparam logic [3:0] OP_RET  = 4'd14;
  localparam logic [3:0] OP_HLT  = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       pc_q, pc_d;
  logic [PTRW-1:0]  rs_ptr_q, rs_ptr_d;
  logic [3:0]       instr_q, instr_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;

  logic [11:0]      mem_q [PROG_WORDS];
  logic [3:0]       rstack_q [RS_DEPTH];

  logic             busy;
  logic             push_en;
  logic [IDXW-1:0]  push_idx;
  logic [IDXW-1:0]  pop_idx;
  logic [PTRW-1:0]  rs_ptr_dec;

  assign busy       = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign push_idx   = IDXW'(rs_ptr_q);
  assign rs_ptr_dec = rs_ptr_q - PTRW'(1);
  assign pop_idx    = IDXW'(rs_ptr_dec);

  // Program memory: not cleared by reset; loads are locked out while running.
  always_ff @(posedge mypc_clock) begin
    if (bus.prog_we && !busy) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Return stack storage; only rs_ptr carries reset state.
  always_ff @(posedge mypc_clock) begin
    if (!mypc_reset && push_en) begin
      rstack_q[push_idx] <= pc_q + 4'd1;
    end
  end

  always_ff @(posedge mypc_clock) begin
    if (mypc_reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      rs_ptr_q <= '0;
      instr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rs_ptr_q <= rs_ptr_d;
      instr_q  <= instr_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rs_ptr_d = rs_ptr_q;
    instr_d  = instr_q;
    a_d      = a_q;
    b_d      = b_q;
    push_en  = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED, S_FAULT: begin
        if (bus.start) begin
          pc_d     = '0;
          rs_ptr_d = '0;
          state_d  = S_FETCH;
        end
      end

      S_FETCH: begin
        {instr_d, a_d, b_d} = mem_q[pc_q];
        state_d             = S_ISSUE;
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Datapath flags reflect the instruction just strobed.
        if (bus.stop_in || (instr_q == OP_HLT)) begin
          state_d = S_HALTED;
        end else if ((instr_q == OP_JZ) && bus.zf_in) begin
          pc_d    = a_q;
          state_d = S_FETCH;
        end else if (instr_q == OP_CALL) begin
          if (rs_ptr_q == PTRW'(RS_DEPTH)) begin
            state_d = S_FAULT;
          end else begin
            push_en  = 1'b1;
            rs_ptr_d = rs_ptr_q + PTRW'(1);
            pc_d     = a_q;
            state_d  = S_FETCH;
          end
        end else if (instr_q == OP_RET) begin
          if (rs_ptr_q == '0) begin
            state_d = S_FAULT;
          end else begin
            rs_ptr_d = rs_ptr_dec;
            pc_d     = rstack_q[pop_idx];
            state_d  = S_FETCH;
          end
        end else begin
          pc_d    = pc_q + 4'd1;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.pc_instr    = instr_q;
  assign bus.A           = a_q;
  assign bus.B           = b_q;
  assign bus.pc          = pc_q;
  // Gated by reset so an aborted instruction never reaches the datapath.
  assign bus.exec_strobe = (state_q == S_ISSUE) && !mypc_reset;
  assign bus.busy        = busy;
  assign bus.halted      = (state_q == S_HALTED);
  assign bus.fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_mypc_sequencer.sv
// Scoreboard bench for mypc_sequencer: stimulus queues the expected
// {pc, instr, A, B} (and optionally the cycle) of every strobe; a monitor
// pops and compares on each exec_strobe.
module tb_mypc_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mypc_sequencer_if bus ();

  mypc_sequencer #(.RS_DEPTH(4), .PROG_WORDS(16)) dut (
    .mypc_clock (clk),
    .mypc_reset (rst),
    .bus        (bus.slave)
  );

  typedef struct {
    int pc;
    int instr;
    int a;
    int b;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int   cyc    = 0;
  int   passed = 0;
  int   total  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void push(input int pc, input int instr, input int a, input int b,
                               input int c);
    exp_t e;
    e.pc = pc; e.instr = instr; e.a = a; e.b = b; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (bus.exec_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        me = exp_q.pop_front();
        check("strobe_pc", int'(bus.pc), me.pc);
        check("strobe_instr", int'(bus.pc_instr), me.instr);
        check("strobe_A", int'(bus.A), me.a);
        check("strobe_B", int'(bus.B), me.b);
        if (me.cyc >= 0) check("strobe_cycle", cyc, me.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input int instr, input int a, input int b);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'(addr);
    bus.prog_data = {4'(instr), 4'(a), 4'(b)};
    tick();
    bus.prog_we   = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int at);
    int n = 0;
    while (!(bus.halted || bus.fault) && n < limit) begin
      tick();
      n++;
    end
    if (!(bus.halted || bus.fault)) check("run_timeout", 0, 1);
    at = cyc;
  endtask

  task automatic check_end(input string tag, input int h, input int f, input int pc);
    check({tag, "_halted"}, int'(bus.halted), h);
    check({tag, "_fault"}, int'(bus.fault), f);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_pc"}, int'(bus.pc), pc);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, int'(bus.pc), 0);
    check({tag, "_instr"}, int'(bus.pc_instr), 0);
    check({tag, "_A"}, int'(bus.A), 0);
    check({tag, "_B"}, int'(bus.B), 0);
    check({tag, "_strobe"}, int'(bus.exec_strobe), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_halted"}, int'(bus.halted), 0);
    check({tag, "_fault"}, int'(bus.fault), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int at;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.zf_in     = 1'b0;
    bus.stop_in   = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Straight line; the start cycle counts as cycle 1, so strobes at 3, 6, 9.
    load(0, 0, 3, 4);
    load(1, 1, 5, 5);
    load(2, 15, 0, 0);
    sc = cyc;
    push(0, 0, 3, 4, sc + 2);
    push(1, 1, 5, 5, sc + 5);
    push(2, 15, 0, 0, sc + 8);
    do_start();
    bus.start = 1'b1;            // start while busy: must be ignored
    tick();
    bus.start = 1'b0;
    wait_done(40, at);
    check("line_halt_cycle", at, sc + 10);
    check_end("line", 1, 0, 2);

    // JZ taken
    load(0, 10, 5, 0);
    load(5, 15, 0, 0);
    load(1, 15, 0, 0);
    bus.zf_in = 1'b1;
    push(0, 10, 5, 0, -1);
    push(5, 15, 0, 0, -1);
    do_start();
    wait_done(40, at);
    check_end("jz_taken", 1, 0, 5);

    // JZ not taken
    bus.zf_in = 1'b0;
    push(0, 10, 5, 0, -1);
    push(1, 15, 0, 0, -1);
    do_start();
    wait_done(40, at);
    check_end("jz_not", 1, 0, 1);

    // CALL / RET
    load(0, 13, 8, 0);
    load(8, 14, 0, 0);
    load(1, 15, 0, 0);
    push(0, 13, 8, 0, -1);
    push(8, 14, 0, 0, -1);
    push(1, 15, 0, 0, -1);
    do_start();
    wait_done(40, at);
    check_end("callret", 1, 0, 1);

    // Five nested CALLs overflow a 4-deep stack
    for (int i = 0; i < 5; i++) begin
      load(i, 13, i + 1, 0);
      push(i, 13, i + 1, 0, -1);
    end
    do_start();
    wait_done(60, at);
    check_end("overflow", 0, 1, 4);

    // RET on empty stack, started from FAULT
    load(0, 14, 0, 0);
    push(0, 14, 0, 0, -1);
    do_start();
    check("restart_fault_clr", int'(bus.fault), 0);
    check("restart_busy", int'(bus.busy), 1);
    check("restart_pc", int'(bus.pc), 0);
    wait_done(40, at);
    check_end("underflow", 0, 1, 0);

    // pc 15 wraps to 0; loops CALL 0->15 until the stack overflows at pc 0
    load(0, 13, 15, 0);
    load(15, 7, 1, 1);
    for (int i = 0; i < 4; i++) begin
      push(0, 13, 15, 0, -1);
      push(15, 7, 1, 1, -1);
    end
    push(0, 13, 15, 0, -1);
    do_start();
    wait_done(100, at);
    check_end("wrap", 0, 1, 0);

    // stop_in on a non-HLT instruction
    load(0, 0, 1, 2);
    bus.stop_in = 1'b1;
    push(0, 0, 1, 2, -1);
    do_start();
    wait_done(40, at);
    check_end("stop", 1, 0, 0);
    bus.stop_in = 1'b0;

    // Reset during ISSUE aborts the instruction
    load(0, 5, 6, 7);
    load(1, 15, 0, 0);
    do_start();
    tick();                      // now in ISSUE
    rst = 1'b1;
    #1;
    check("reset_issue_strobe", int'(bus.exec_strobe), 0);
    tick();
    rst = 1'b0;
    check_reset_vals("post_reset");

    // Write while busy is dropped
    push(0, 5, 6, 7, -1);
    push(1, 15, 0, 0, -1);
    do_start();
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd0;
    bus.prog_data = {4'd15, 4'd9, 4'd9};
    tick();
    bus.prog_we   = 1'b0;
    wait_done(40, at);
    check_end("busy_write", 1, 0, 1);
    push(0, 5, 6, 7, -1);
    push(1, 15, 0, 0, -1);
    do_start();
    wait_done(40, at);
    check_end("busy_write_rerun", 1, 0, 1);

    // Write and start in the same cycle: first fetch sees new data
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd0;
    bus.prog_data = {4'd15, 4'd9, 4'd9};
    bus.start     = 1'b1;
    push(0, 15, 9, 9, -1);
    tick();
    bus.prog_we   = 1'b0;
    bus.start     = 1'b0;
    wait_done(40, at);
    check_end("we_start", 1, 0, 0);

    repeat (2) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mypc_sequencer.md
Name: mypc_sequencer

Overview:
- Program sequencer for the 4-bit computer datapath.
- Holds a loadable 16-entry program memory; each entry is 12 bits {instr[3:0], A[3:0], B[3:0]}.
- Fetches entries and drives pc_instr/A/B with a one-cycle execute strobe into the datapath, which is clock-enabled by that strobe.
- Samples the datapath's zf/stop_flag to resolve JZ and HLT, and keeps its own return stack for CALL/RET.

Parameters:
- RS_DEPTH, 4, number of return-stack entries (2..8).
- PROG_WORDS, 16, program memory depth; fixed at 16 by the 4-bit pc.

Ports:
- mypc_clock  in  1  single system clock, rising edge.
- mypc_reset  in  1  synchronous, active-high reset.
- start  in  1  begin execution at pc=0; honoured only in IDLE, HALTED or FAULT.
- prog_we  in  1  program-memory write enable.
- prog_addr  in  4  program-memory write address.
- prog_data  in  12  write data {instr, A, B}.
- zf_in  in  1  datapath zero flag.
- stop_in  in  1  datapath stop_flag.
- pc_instr  out  4  instruction to datapath.
- A  out  4  operand A to datapath.
- B  out  4  operand B to datapath.
- exec_strobe  out  1  one-cycle datapath enable.
- pc  out  4  address of the current/next instruction.
- busy  out  1  high in FETCH, ISSUE and WAIT.
- halted  out  1  high in HALTED.
- fault  out  1  high in FAULT.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high: mypc_reset sampled high at a mypc_clock rising edge resets the block.
  - Reset values: state=IDLE; pc=0; rs_ptr=0; pc_instr=0, A=0, B=0; exec_strobe=0; busy=0; halted=0; fault=0.
  - Program memory contents are not cleared by reset.
  - Reset mid-instruction aborts it immediately; any exec_strobe in that cycle is forced to 0.
- States: IDLE, FETCH, ISSUE, WAIT, HALTED, FAULT.
  - IDLE, HALTED, FAULT: start=1 -> pc<=0, rs_ptr<=0, go to FETCH.
  - FETCH: latch mem[pc] into the pc_instr/A/B registers; go to ISSUE.
  - ISSUE: exec_strobe=1 for exactly this cycle; outputs held stable; go to WAIT.
  - WAIT: sample zf_in and stop_in (the datapath updated on the strobe edge), resolve the next pc, then go to FETCH, HALTED or FAULT.
- Throughput: exactly 3 cycles per instruction; exactly one strobe per instruction.
- Next-pc resolution in WAIT, in priority order:
  1. stop_in=1 or pc_instr=15 -> HALTED; pc unchanged.
  2. pc_instr=10 (JZ) and zf_in=1 -> pc<=A.
  3. pc_instr=13 (CALL):
     - rs_ptr==RS_DEPTH -> FAULT (overflow).
     - else rstack[rs_ptr]<=pc+1, rs_ptr++, pc<=A.
  4. pc_instr=14 (RET):
     - rs_ptr==0 -> FAULT (underflow).
     - else rs_ptr--, pc<=rstack[rs_ptr-1].
  5. Otherwise pc<=pc+1, mod 16 (15 wraps to 0).
- Return addresses: pc+1 wraps mod 16, so a CALL at 15 stores 0.
- Output holds: pc_instr/A/B hold their last values in every state except FETCH; busy = state in {FETCH, ISSUE, WAIT}.
- Program load:
  - prog_we is honoured only when busy=0; writes while busy are ignored, with no side effects.
  - prog_we and start in the same cycle: the write commits, and the first FETCH reads the new data.
- Start while busy: ignored.
- Inputs that are don't-care: zf_in and stop_in are ignored outside WAIT.
- Reading a memory location that was never written: result is unspecified. Benches always load the program first.

Test Plan:
1. Straight line:
   - Load mem0={0,3,4}, mem1={1,5,5}, mem2={15,0,0}; pulse start.
   - Strobes occur at cycles 3, 6, 9 after start, carrying instr 0, then 1, then 15.
   - HALTED is entered one cycle after the third strobe with pc=2; halted=1, busy=0.
2. JZ taken and not taken:
   - mem0={10,5,0}, zf_in=1 in WAIT -> next fetch address is 5.
   - Rerun with zf_in=0 -> next fetch address is 1.
3. CALL/RET:
   - mem0={13,8,0}, mem8={14,0,0}, mem1={15,0,0}.
   - Fetch order is 0, 8, 1, then HALTED; rs_ptr returns to 0.
4. Stack faults:
   - Five nested CALLs with RS_DEPTH=4 -> FAULT after the fifth strobe.
   - RET with an empty stack -> FAULT.
   - start from FAULT clears fault and restarts at pc=0.
5. Wrap and stop_in:
   - mem15={7,1,1} with pc reaching 15 -> next fetch address is 0.
   - stop_in=1 during WAIT of a non-HLT instruction -> HALTED.
6. Reset and load interlock:
   - mypc_reset asserted in the ISSUE cycle -> exec_strobe=0 that cycle; all outputs at reset values on the next cycle.
   - prog_we while busy leaves memory unchanged, confirmed by a later run.
